// File: rtl/ped_pkg.sv
// ped_pkg: shared definitions for the pedestrian request block.
//   ped_state_e      : 3-bit FSM state encodings (also visible on Estado)
//   *_CYCLES_DEF     : default timing parameters
//   TMR_W / CNT_W    : walk/flash timer and debounce counter widths
package ped_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_WAIT     = 3'd2,
        ST_WALK     = 3'd3,
        ST_FLASH    = 3'd4
    } ped_state_e;

    localparam int unsigned DEB_CYCLES_DEF   = 4;
    localparam int unsigned WALK_CYCLES_DEF  = 8;
    localparam int unsigned FLASH_CYCLES_DEF = 4;

    localparam int unsigned TMR_W = 8;
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/pedestrian_request_sincronizador.sv
// sincronizador: two-flop synchronizer for an asynchronous level input.
//   clk : sampling clock
//   rst : asynchronous active-low reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
module sincronizador (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pedestrian_request.sv
// pedestrian_request: push-button pedestrian crossing request FSM.
//   clk           : clock, all state changes on rising edge
//   rst           : asynchronous active-low reset
//   Boton         : raw push-button (async, may bounce)
//   Pasar_Persona : pedestrian-phase grant from the traffic-light controller
//   Solicitud     : crossing request to the controller
//   Caminar       : steady walk lamp
//   Alto          : don't-walk lamp (flashes during the FLASH phase)
//   Espera        : "request registered, wait" indicator
//   Estado        : raw state register, for debug
module pedestrian_request
    import ped_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned WALK_CYCLES  = WALK_CYCLES_DEF,
    parameter int unsigned FLASH_CYCLES = FLASH_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Boton,
    input  logic       Pasar_Persona,
    output logic       Solicitud,
    output logic       Caminar,
    output logic       Alto,
    output logic       Espera,
    output logic [2:0] Estado
);

    localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEB_CYCLES);
    localparam logic [TMR_W-1:0] WALK_LOAD  = TMR_W'(WALK_CYCLES - 1);
    localparam logic [TMR_W-1:0] FLASH_LOAD = TMR_W'(FLASH_CYCLES - 1);

    logic             boton_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] deb_cnt;
    logic [TMR_W-1:0] timer;
    logic             flash;

    sincronizador u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Boton),
        .q   (boton_s)
    );

    // State held as a plain 3-bit vector so the unused codes 5..7 are
    // representable and fall back to IDLE through the default branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            deb_cnt <= '0;
            timer   <= '0;
            flash   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (boton_s) begin
                        state   <= ST_DEBOUNCE;
                        deb_cnt <= CNT_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!boton_s)
                        state <= ST_IDLE;
                    else if (deb_cnt == DEB_MAX)
                        state <= ST_WAIT;
                    else
                        deb_cnt <= deb_cnt + 1'b1;
                end
                ST_WAIT: begin
                    // Button activity is irrelevant here; only the grant moves us on.
                    if (Pasar_Persona) begin
                        state <= ST_WALK;
                        timer <= WALK_LOAD;
                    end
                end
                ST_WALK: begin
                    if (timer == '0) begin
                        state <= ST_FLASH;
                        timer <= FLASH_LOAD;
                        flash <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_FLASH: begin
                    flash <= ~flash;
                    if (timer == '0)
                        state <= ST_IDLE;
                    else
                        timer <= timer - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Solicitud = 1'b0;
        Caminar   = 1'b0;
        Alto      = 1'b1;
        Espera    = 1'b0;
        case (state)
            ST_WAIT: begin
                Solicitud = 1'b1;
                Espera    = 1'b1;
            end
            ST_WALK: begin
                Caminar = 1'b1;
                Alto    = 1'b0;
            end
            ST_FLASH: Alto = flash;
            default: ;
        endcase
    end

    assign Estado = state;

endmodule

// File: tb/tb_pedestrian_request.sv
module tb_pedestrian_request;

    localparam int DEB   = 4;
    localparam int WALK  = 8;
    localparam int FLASH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       Boton;
    logic       Pasar_Persona;
    logic       Solicitud;
    logic       Caminar;
    logic       Alto;
    logic       Espera;
    logic [2:0] Estado;

    pedestrian_request #(
        .DEB_CYCLES   (DEB),
        .WALK_CYCLES  (WALK),
        .FLASH_CYCLES (FLASH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Boton         (Boton),
        .Pasar_Persona (Pasar_Persona),
        .Solicitud     (Solicitud),
        .Caminar       (Caminar),
        .Alto          (Alto),
        .Espera        (Espera),
        .Estado        (Estado)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0..4 (idle, debounce, wait, walk, flash),
    // run = consecutive synchronized-high samples, left = phase cycles remaining,
    // fel = cycles already spent in flash (stop lamp lit on odd ones).
    int   m_phase, m_run, m_left, m_fel;
    logic m_b1, m_b2;
    logic m_bad = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_b1 <= 1'b0; m_b2 <= 1'b0;
            m_phase <= 0; m_run <= 0; m_left <= 0; m_fel <= 0;
        end else begin
            m_b1 <= Boton;
            m_b2 <= m_b1;
            if (m_bad) m_phase <= 0;
            else case (m_phase)
                0: if (m_b2) begin m_phase <= 1; m_run <= 1; end
                1: begin
                    if (!m_b2) m_phase <= 0;
                    else if (m_run == DEB) m_phase <= 2;
                    else m_run <= m_run + 1;
                end
                2: if (Pasar_Persona) begin m_phase <= 3; m_left <= WALK; end
                3: begin
                    if (m_left == 1) begin m_phase <= 4; m_left <= FLASH; m_fel <= 0; end
                    else m_left <= m_left - 1;
                end
                4: begin
                    m_fel <= m_fel + 1;
                    if (m_left == 1) m_phase <= 0;
                    else m_left <= m_left - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // {Solicitud, Caminar, Alto, Espera, Estado}
    function automatic logic [7:0] model_out();
        logic [7:0] v;
        case (m_phase)
            2:       v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
            3:       v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
            4:       v = {1'b0, 1'b0, 1'b0, (m_fel % 2 == 1), 1'b0, 3'd4};
            1:       v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
            default: v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        endcase
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {1'b0, Solicitud, Caminar, Alto, Espera, Estado};
    endfunction

    logic chk_en = 1'b0;
    int   cam_cnt = 0, sol_cnt = 0, saw_wait = 0, idle_bad = 0;

    always @(negedge clk) begin
        if (chk_en) check("model_cmp", dut_out(), model_out());
        if (Caminar)        cam_cnt++;
        if (Solicitud)      sol_cnt++;
        if (Estado == 3'd2) saw_wait++;
        if (Alto !== 1'b1 || Solicitud !== 1'b0 || Estado !== 3'd0) idle_bad++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] IDLE_VEC = 8'b0001_0000;

    initial begin
        rst = 1'b0; Boton = 1'b0; Pasar_Persona = 1'b0;
        #2;
        check("reset_outputs", dut_out(), IDLE_VEC);
        #10 rst = 1'b1;
        chk_en = 1'b1;

        // Reset then idle for 20 cycles
        @(negedge clk); idle_bad = 0;
        tick(20);
        check("idle_20", 8'(idle_bad), 8'd0);

        // Full crossing, button held throughout
        @(posedge clk); #1 Boton = 1'b1;
        cam_cnt = 0; sol_cnt = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            case (e)
                6:  check("sol_before_7", 8'(Solicitud), 8'd0);
                7:  check("sol_at_7", 8'(Solicitud), 8'd1);
                11: Pasar_Persona = 1'b1;
                12: begin Pasar_Persona = 1'b0; check("walk_at_12", 8'(Caminar), 8'd1); end
                20: check("flash0", {Alto, 4'd0, Estado}, {1'b0, 4'd0, 3'd4});
                21: check("flash1", 8'(Alto), 8'd1);
                22: check("flash2", 8'(Alto), 8'd0);
                23: check("flash3", 8'(Alto), 8'd1);
                24: check("back_idle", dut_out(), IDLE_VEC);
                default: ;
            endcase
        end
        check("walk_len", 8'(cam_cnt), 8'd8);
        check("sol_len", 8'(sol_cnt), 8'd5);
        Boton = 1'b0;
        tick(10);
        check("idle_after_cross", 8'(Estado), 8'd0);

        // Bounce: 3 high, 1 low, 3 high
        saw_wait = 0;
        Boton = 1'b1; tick(3);
        Boton = 1'b0; tick(1);
        Boton = 1'b1; tick(3);
        Boton = 1'b0; tick(6);
        check("bounce_no_wait", 8'(saw_wait), 8'd0);
        check("bounce_idle", 8'(Estado), 8'd0);

        // Stray grant in IDLE, then in WALK/FLASH
        Pasar_Persona = 1'b1; tick(5);
        check("stray_idle", 8'(Estado), 8'd0);
        Pasar_Persona = 1'b0;
        Boton = 1'b1; tick(7);
        check("wait_reached", 8'(Estado), 8'd2);
        cam_cnt = 0;
        Boton = 1'b0; Pasar_Persona = 1'b1;
        tick(13);
        Pasar_Persona = 1'b0;
        check("stray_walk_len", 8'(cam_cnt), 8'd8);
        check("stray_end_idle", 8'(Estado), 8'd0);
        tick(4);

        // Reset during WALK cycle 3
        Boton = 1'b1; tick(7);
        Boton = 1'b0; Pasar_Persona = 1'b1; tick(1);
        Pasar_Persona = 1'b0; tick(2);
        check("in_walk", 8'(Estado), 8'd3);
        #3 rst = 1'b0;
        #1 check("reset_mid_walk", dut_out(), IDLE_VEC);
        @(negedge clk); rst = 1'b1;
        tick(10);
        check("idle_after_reset", dut_out(), IDLE_VEC);

        // Illegal encoding recovery
        chk_en = 1'b0;
        @(negedge clk);
        force dut.state = 3'd6;
        #1 release dut.state;
        #1 check("forced_code", 8'(Estado), 8'd6);
        m_bad = 1'b1;
        @(posedge clk); #1;
        check("recover_idle", dut_out(), IDLE_VEC);
        m_bad = 1'b0;
        chk_en = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pedestrian_request.md
PEDESTRIAN_REQUEST -- requirements
Module: pedestrian_request

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized-high cycles of Boton that count as a valid press (range 1..15).
REQ-002 Parameter WALK_CYCLES, default 8: number of cycles the walk lamp stays steady (range 1..255).
REQ-003 Parameter FLASH_CYCLES, default 4: number of cycles of the flashing-stop phase (range 1..255).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 Boton  input  1  raw pedestrian push-button, asynchronous to clk, may bounce.
REQ-007 Pasar_Persona  input  1  grant from the traffic-light controller; high for at least one cycle while the pedestrian phase is granted.
REQ-008 Solicitud  output  1  request to the traffic-light controller (drives its IN input).
REQ-009 Caminar  output  1  steady walk lamp.
REQ-010 Alto  output  1  don't-walk lamp.
REQ-011 Espera  output  1  "request registered, wait" indicator.
REQ-012 Estado  output  3  current state encoding, for debug.

Function
REQ-013 Boton shall pass through a two-flop synchronizer before any use; all later references to Boton mean the synchronized value.
REQ-014 The FSM shall have states IDLE=0, DEBOUNCE=1, WAIT=2, WALK=3, FLASH=4; encodings 5..7 shall go to IDLE on the next edge.
REQ-015 IDLE: Boton=1 -> DEBOUNCE with the debounce count set to 1; otherwise remain in IDLE.
REQ-016 DEBOUNCE: Boton=0 -> IDLE; Boton=1 with count==DEB_CYCLES -> WAIT; otherwise increment the count and remain.
REQ-017 WAIT: Pasar_Persona=1 -> WALK with the timer loaded to WALK_CYCLES-1; otherwise remain (no timeout).
REQ-018 WALK: the timer decrements each cycle; the edge on which the timer equals 0 -> FLASH with the timer loaded to FLASH_CYCLES-1 and the flash bit cleared.
REQ-019 FLASH: the flash bit toggles every cycle and the timer decrements; the edge on which the timer equals 0 -> IDLE.
REQ-020 Outputs shall be a pure function of the state register and the flash bit (Moore), as follows:
- IDLE: Alto=1, all other outputs 0.
- DEBOUNCE: Alto=1, all other outputs 0.
- WAIT: Alto=1, Solicitud=1, Espera=1, Caminar=0.
- WALK: Caminar=1, all other outputs 0.
- FLASH: Alto equals the flash bit, all other outputs 0.
REQ-021 Latency: with Boton held high from edge 0, Solicitud shall rise on edge DEB_CYCLES+3 (edge 7 at default).
REQ-022 Pasar_Persona shall be ignored in every state except WAIT.
REQ-023 Button presses during WAIT, WALK, or FLASH shall be ignored and not queued; a press still held when FLASH exits restarts debounce from IDLE.
REQ-024 If Pasar_Persona=1 and Boton changes on the same edge in WAIT, the grant shall take priority.
REQ-025 WALK shall occupy exactly WALK_CYCLES cycles and FLASH exactly FLASH_CYCLES cycles.

Reset
REQ-026 While rst=0, the following shall hold immediately, independent of clk:
- state=IDLE.
- Both synchronizer flops, the debounce count, the timer, and the flash bit are 0.
- Alto=1; Solicitud, Caminar, and Espera are 0.
REQ-027 Reset asserted mid-operation (including WAIT or WALK) shall drop Solicitud and Caminar immediately; after rst rises, operation starts from IDLE.

Structure
REQ-028 Package ped_pkg shall hold:
- the state enum (3 bits) and its encodings;
- default values for DEB_CYCLES, WALK_CYCLES, and FLASH_CYCLES;
- timer width (8) and debounce count width (4).
REQ-029 The two-flop synchronizer shall be a separate sub-module named sincronizador, with ports clk, rst, d, q and reset value 0.

Verification
REQ-030 Reset then idle: rst=0 then 1, Boton=0 for 20 cycles -> Alto=1, Solicitud=0, Estado=0 throughout.
REQ-031 Bounce: synchronized Boton high for 3 cycles, low for 1, high for 3 (DEB_CYCLES=4) -> never reaches WAIT; Solicitud stays 0.
REQ-032 Full crossing: Boton held high, Pasar_Persona pulsed for 1 cycle at edge 12 -> Solicitud=1 on edges 7..12; Caminar=1 for 8 cycles; Alto pattern 0,1,0,1 across FLASH; back to IDLE with Alto=1.
REQ-033 Stray grant: Pasar_Persona=1 in IDLE and in WALK -> no state change beyond the normal timer behaviour.
REQ-034 Reset mid-WALK: rst=0 at WALK cycle 3 -> Caminar=0 and Alto=1 immediately; after release, Boton=0 keeps IDLE.
REQ-035 Encoding recovery: state forced to 6 -> IDLE on the next edge with IDLE outputs.
